router_fsm: RTL and testbench
=============================

Name: router_fsm

Overview:
- Control FSM of a 1-to-3 packet router; one instance sits between the input port and three output FIFOs.
- Decodes the 2-bit destination address from the packet header.
- Sequences header, payload and parity loading into the synchroniser/register blocks.
- Handles FIFO-full stalls and per-destination soft resets. Outputs are Moore state flags that drive the datapath.

Parameters:
- None. State encodings are fixed local constants, 3 bits each:
  - DECODE_ADDRESS = 000
  - LOAD_FIRST_DATA = 001
  - LOAD_DATA = 010
  - FIFO_FULL_STATE = 011
  - LOAD_AFTER_FULL = 100
  - LOAD_PARITY = 101
  - CHECK_PARITY_ERROR = 110
  - WAIT_TILL_EMPTY = 111

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-high reset. Despite the name, a level of 1 resets.
- pkt_valid  in  1  packet byte stream valid.
- data_in  in  2  destination address (header bits [1:0]); 0, 1, 2 are valid, 3 is invalid.
- low_pkt_valid  in  1  end-of-packet indication from the register block.
- parity_done  in  1  parity byte already captured.
- fifo_full  in  1  full flag of the selected FIFO.
- soft_reset_0, soft_reset_1, soft_reset_2  in  1 each  per-FIFO timeout soft reset.
- fifo_empty_0, fifo_empty_1, fifo_empty_2  in  1 each  FIFO empty flags.
- busy  out  1  router cannot accept new input bytes.
- detect_add  out  1  in DECODE_ADDRESS.
- lfd_state  out  1  in LOAD_FIRST_DATA.
- ld_state  out  1  in LOAD_DATA.
- full_state  out  1  in FIFO_FULL_STATE.
- laf_state  out  1  in LOAD_AFTER_FULL.
- rst_int_reg  out  1  in CHECK_PARITY_ERROR.
- write_enb_reg  out  1  FIFO write enable.

Behaviour:
- Reset
  - resetn=1 forces state to DECODE_ADDRESS and the address register to 0, immediately (asynchronous).
  - Resulting outputs: detect_add=1; all other outputs 0.
- Address latch
  - In DECODE_ADDRESS with pkt_valid=1, data_in is captured into a 2-bit address register on the clock edge.
  - The register holds its value in all other states.
- Transitions (evaluated on the rising edge)
  - DECODE_ADDRESS:
    - pkt_valid=1, data_in=k in {0,1,2}, fifo_empty_k=1 -> LOAD_FIRST_DATA.
    - pkt_valid=1, data_in=k, fifo_empty_k=0 -> WAIT_TILL_EMPTY.
    - Otherwise, including data_in=3 -> stay.
  - LOAD_FIRST_DATA: -> LOAD_DATA unconditionally.
  - LOAD_DATA:
    - fifo_full=1 -> FIFO_FULL_STATE.
    - Else if pkt_valid=0 -> LOAD_PARITY.
    - Else stay.
  - FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL:
    - parity_done=1 -> DECODE_ADDRESS.
    - Else if low_pkt_valid=1 -> LOAD_PARITY.
    - Else -> LOAD_DATA.
  - LOAD_PARITY: -> CHECK_PARITY_ERROR unconditionally.
  - CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: fifo_empty of the latched address = 1 -> LOAD_FIRST_DATA; else stay.
- Soft reset
  - In any state other than DECODE_ADDRESS: if soft_reset_k=1 and latched address = k, the next state is DECODE_ADDRESS.
  - Soft reset overrides all other transitions.
  - Soft reset for a non-matching address is ignored.
  - In DECODE_ADDRESS, soft resets are ignored.
- Outputs (combinational decode of the current state only, no input dependence)
  - detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg: each high only in its own state.
  - write_enb_reg = 1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Latency: every transition takes exactly one clock; no output registers.

Test Plan:
- Reset/soft reset:
  - Assert resetn=1 mid-operation -> detect_add=1, busy=0, write_enb_reg=0 immediately.
  - Drive a packet to address 2, then soft_reset_2=1 for one cycle while in LOAD_DATA -> DECODE_ADDRESS next edge.
  - soft_reset_0 while in LOAD_DATA for the same packet -> ignored, stays in LOAD_DATA.
- Normal packet:
  - pkt_valid=1, data_in=2, fifo_empty_2=1 -> LOAD_FIRST_DATA (lfd_state=1, busy=1), then LOAD_DATA (ld_state=1, write_enb_reg=1, busy=0).
  - Drop pkt_valid -> LOAD_PARITY (write_enb_reg=1, busy=1) -> CHECK_PARITY_ERROR (rst_int_reg=1) -> DECODE_ADDRESS.
- Full stall with low_pkt_valid:
  - In LOAD_DATA, fifo_full=1 -> full_state=1, busy=1, write_enb_reg=0.
  - fifo_full=0 -> laf_state=1, write_enb_reg=1.
  - parity_done=0, low_pkt_valid=1 -> LOAD_PARITY.
- Full stall without low_pkt_valid:
  - Same stall, then low_pkt_valid=0, parity_done=0 -> back to LOAD_DATA.
  - From LOAD_AFTER_FULL with parity_done=1 -> DECODE_ADDRESS.
- Busy destination:
  - pkt_valid=1, data_in=1, fifo_empty_1=0 -> WAIT_TILL_EMPTY (busy=1).
  - Hold 3 cycles -> remains in WAIT_TILL_EMPTY.
  - fifo_empty_1=1 -> LOAD_FIRST_DATA.
- Invalid address / idle:
  - data_in=3 with pkt_valid=1, or pkt_valid=0 -> stays in DECODE_ADDRESS, detect_add=1.
  - CHECK_PARITY_ERROR with fifo_full=1 -> FIFO_FULL_STATE.

Source files
------------

// File: rtl/router_fsm.sv
// Control FSM of a 1-to-3 packet router: decodes the header address, sequences
// header/payload/parity loading, and handles FIFO-full stalls and per-FIFO soft resets.
module router_fsm (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       low_pkt_valid,
    input  logic       parity_done,
    input  logic       fifo_full,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    output logic       busy,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       full_state,
    output logic       laf_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'b000,
        LOAD_FIRST_DATA    = 3'b001,
        LOAD_DATA          = 3'b010,
        FIFO_FULL_STATE    = 3'b011,
        LOAD_AFTER_FULL    = 3'b100,
        LOAD_PARITY        = 3'b101,
        CHECK_PARITY_ERROR = 3'b110,
        WAIT_TILL_EMPTY    = 3'b111
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_addr;
    logic       w_in_empty;
    logic       w_addr_empty;
    logic       w_soft_rst;

    // Empty flag of the FIFO named by the incoming header; address 3 has no FIFO.
    always_comb begin
        w_in_empty = 1'b0;
        case (data_in)
            2'd0:    w_in_empty = fifo_empty_0;
            2'd1:    w_in_empty = fifo_empty_1;
            2'd2:    w_in_empty = fifo_empty_2;
            default: w_in_empty = 1'b0;
        endcase
    end

    always_comb begin
        w_addr_empty = 1'b0;
        w_soft_rst   = 1'b0;
        case (r_addr)
            2'd0: begin
                w_addr_empty = fifo_empty_0;
                w_soft_rst   = soft_reset_0;
            end
            2'd1: begin
                w_addr_empty = fifo_empty_1;
                w_soft_rst   = soft_reset_1;
            end
            2'd2: begin
                w_addr_empty = fifo_empty_2;
                w_soft_rst   = soft_reset_2;
            end
            default: begin
                w_addr_empty = 1'b0;
                w_soft_rst   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            r_state <= DECODE_ADDRESS;
            r_addr  <= 2'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == DECODE_ADDRESS && pkt_valid)
                r_addr <= data_in;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DECODE_ADDRESS: begin
                if (pkt_valid && data_in != 2'd3)
                    w_next_state = w_in_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: w_next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    w_next_state = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    w_next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    w_next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    w_next_state = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    w_next_state = LOAD_PARITY;
                else
                    w_next_state = LOAD_DATA;
            end
            LOAD_PARITY: w_next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (w_addr_empty)
                    w_next_state = LOAD_FIRST_DATA;
            end
            default: w_next_state = DECODE_ADDRESS;
        endcase
        // A timeout on the FIFO being written abandons the packet from any busy state.
        if (r_state != DECODE_ADDRESS && w_soft_rst)
            w_next_state = DECODE_ADDRESS;
    end

    always_comb begin
        detect_add    = (r_state == DECODE_ADDRESS);
        lfd_state     = (r_state == LOAD_FIRST_DATA);
        ld_state      = (r_state == LOAD_DATA);
        full_state    = (r_state == FIFO_FULL_STATE);
        laf_state     = (r_state == LOAD_AFTER_FULL);
        rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
        write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                        (r_state == LOAD_AFTER_FULL);
        busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
    end

    assign fsm_state = r_state;

endmodule

// File: tb/tb_router_fsm.sv
// Directed scoreboard bench for router_fsm: each step queues the expected state
// and flag vector, and the value observed after the clock edge is checked against it.
module tb_router_fsm;

    localparam logic [2:0] S_DA  = 3'b000;
    localparam logic [2:0] S_LFD = 3'b001;
    localparam logic [2:0] S_LD  = 3'b010;
    localparam logic [2:0] S_FF  = 3'b011;
    localparam logic [2:0] S_LAF = 3'b100;
    localparam logic [2:0] S_LP  = 3'b101;
    localparam logic [2:0] S_CPE = 3'b110;
    localparam logic [2:0] S_WTE = 3'b111;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       low_pkt_valid;
    logic       parity_done;
    logic       fifo_full;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       busy, detect_add, lfd_state, ld_state, full_state;
    logic       laf_state, rst_int_reg, write_enb_reg;
    logic [2:0] fsm_state;

    logic [10:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    router_fsm dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .low_pkt_valid(low_pkt_valid), .parity_done(parity_done), .fifo_full(fifo_full),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    // Expected {state, busy, detect_add, lfd, ld, full, laf, rst_int, wen}.
    function automatic logic [10:0] expect_vec(input logic [2:0] s);
        logic b, wen;
        b   = !(s == S_DA || s == S_LD);
        wen = (s == S_LD) || (s == S_LP) || (s == S_LAF);
        return {s, b, s == S_DA, s == S_LFD, s == S_LD, s == S_FF, s == S_LAF, s == S_CPE, wen};
    endfunction

    function automatic logic [10:0] observed();
        return {fsm_state, busy, detect_add, lfd_state, ld_state, full_state,
                laf_state, rst_int_reg, write_enb_reg};
    endfunction

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%b required=%b", tag, obs, exp);
        end
    endtask

    // driver: inputs change on the falling edge
    task automatic drive(input logic pv, input logic [1:0] din, input logic lpv,
                         input logic pd, input logic ff, input logic [2:0] sr,
                         input logic [2:0] fe);
        pkt_valid     = pv;
        data_in       = din;
        low_pkt_valid = lpv;
        parity_done   = pd;
        fifo_full     = ff;
        {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = fe;
    endtask

    task automatic tick(input string tag, input logic [2:0] exp_state);
        exp_q.push_back(expect_vec(exp_state));
        @(posedge clock);
        #1;
        check(tag, observed(), exp_q.pop_front());
        @(negedge clock);
    endtask

    initial begin
        resetn = 1'b1;
        drive(0, 2'd0, 0, 0, 0, 3'b000, 3'b111);
        repeat (2) @(posedge clock);
        #1;
        exp_q.push_back(expect_vec(S_DA));
        check("reset", observed(), exp_q.pop_front());
        @(negedge clock);
        resetn = 1'b0;

        // normal packet to address 2
        drive(1, 2'd2, 0, 0, 0, 3'b000, 3'b111); tick("norm_lfd", S_LFD);
        drive(1, 2'd1, 0, 0, 0, 3'b000, 3'b111); tick("norm_ld", S_LD);
        tick("norm_ld_hold", S_LD);
        drive(0, 2'd0, 0, 0, 0, 3'b000, 3'b111); tick("norm_lp", S_LP);
        tick("norm_cpe", S_CPE);
        tick("norm_da", S_DA);

        // soft reset: non-matching ignored, matching aborts
        drive(1, 2'd2, 0, 0, 0, 3'b000, 3'b111); tick("sr_lfd", S_LFD);
        drive(1, 2'd2, 0, 0, 0, 3'b000, 3'b111); tick("sr_ld", S_LD);
        drive(1, 2'd2, 0, 0, 0, 3'b001, 3'b111); tick("sr0_ignored", S_LD);
        drive(1, 2'd2, 0, 0, 0, 3'b100, 3'b111); tick("sr2_abort", S_DA);

        // full stall then low_pkt_valid, CPE with full, stall, parity_done
        drive(1, 2'd0, 0, 0, 0, 3'b000, 3'b111); tick("st1_lfd", S_LFD);
        drive(1, 2'd0, 0, 0, 0, 3'b000, 3'b111); tick("st1_ld", S_LD);
        drive(1, 2'd0, 0, 0, 1, 3'b000, 3'b111); tick("st1_full", S_FF);
        tick("st1_full_hold", S_FF);
        drive(1, 2'd0, 0, 0, 0, 3'b000, 3'b111); tick("st1_laf", S_LAF);
        drive(0, 2'd0, 1, 0, 0, 3'b000, 3'b111); tick("st1_lp", S_LP);
        drive(0, 2'd0, 1, 0, 1, 3'b000, 3'b111); tick("st1_cpe", S_CPE);
        tick("cpe_to_full", S_FF);
        drive(0, 2'd0, 0, 0, 0, 3'b000, 3'b111); tick("st1_laf2", S_LAF);
        drive(0, 2'd0, 0, 1, 0, 3'b000, 3'b111); tick("laf_parity_done", S_DA);

        // full stall without low_pkt_valid
        drive(1, 2'd1, 0, 0, 0, 3'b000, 3'b111); tick("st2_lfd", S_LFD);
        drive(1, 2'd1, 0, 0, 0, 3'b000, 3'b111); tick("st2_ld", S_LD);
        drive(1, 2'd1, 0, 0, 1, 3'b000, 3'b111); tick("st2_full", S_FF);
        drive(1, 2'd1, 0, 0, 0, 3'b000, 3'b111); tick("st2_laf", S_LAF);
        tick("laf_to_ld", S_LD);
        drive(0, 2'd1, 0, 0, 0, 3'b000, 3'b111); tick("st2_lp", S_LP);
        tick("st2_cpe", S_CPE);
        tick("st2_da", S_DA);

        // busy destination; WTE follows the latched address, not data_in
        drive(1, 2'd1, 0, 0, 0, 3'b000, 3'b101); tick("wte_enter", S_WTE);
        drive(0, 2'd0, 0, 0, 0, 3'b000, 3'b101);
        for (int i = 0; i < 3; i++) tick($sformatf("wte_hold%0d", i), S_WTE);
        drive(0, 2'd1, 0, 0, 0, 3'b000, 3'b111); tick("wte_lfd", S_LFD);
        drive(1, 2'd1, 0, 0, 0, 3'b000, 3'b111); tick("wte_ld", S_LD);

        // asynchronous reset mid-packet takes effect without a clock edge
        resetn = 1'b1;
        #1;
        exp_q.push_back(expect_vec(S_DA));
        check("async_reset", observed(), exp_q.pop_front());
        tick("reset_held", S_DA);
        resetn = 1'b0;

        // invalid address, idle, soft reset ignored in DECODE_ADDRESS
        drive(1, 2'd3, 0, 0, 0, 3'b000, 3'b111); tick("addr3_stay", S_DA);
        drive(0, 2'd2, 0, 0, 0, 3'b000, 3'b111); tick("idle_stay", S_DA);
        drive(0, 2'd0, 0, 0, 0, 3'b111, 3'b111); tick("sr_in_da", S_DA);

        // soft reset from WAIT_TILL_EMPTY, and random soft-reset sweep in LD
        drive(1, 2'd0, 0, 0, 0, 3'b000, 3'b110); tick("wte0_enter", S_WTE);
        drive(0, 2'd0, 0, 0, 0, 3'b001, 3'b110); tick("wte0_sr", S_DA);
        for (int i = 0; i < 6; i++) begin
            logic [1:0] a;
            logic [2:0] sr;
            a  = 2'($urandom_range(0, 2));
            sr = 3'($urandom_range(0, 7));
            drive(1, a, 0, 0, 0, 3'b000, 3'b111); tick("rnd_lfd", S_LFD);
            drive(1, 2'd3, 0, 0, 0, 3'b000, 3'b111); tick("rnd_ld", S_LD);
            drive(1, 2'd3, 0, 0, 0, sr, 3'b111);
            tick($sformatf("rnd_sr a=%0d sr=%b", a, sr), sr[a] ? S_DA : S_LD);
            if (!sr[a]) begin
                drive(1, 2'd3, 0, 0, 0, 3'b111, 3'b111); tick("rnd_sr_all", S_DA);
            end
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain observed=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
